// File: rtl/print_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : print_job_sched
// Brief    : Round-robin scheduler sharing one page printer between NREQ
//            requesters; tracks printer status and reports done/timeout.
//            Optional macro PRN_SCHED_PRIO_EN gives requester 0 strict priority.
// Revision : 1.0 - initial release
// ============================================================================
module print_job_sched #(
  parameter int NREQ    = 4,
  parameter int PAGES_W = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*PAGES_W-1:0]   req_pages,
  output logic [NREQ-1:0]           req_ready,
  output logic                      prn_push,
  output logic [PAGES_W-1:0]        prn_pages,
  input  logic                      prn_warm,
  input  logic                      prn_loadpage,
  input  logic                      prn_printpage,
  output logic                      busy,
  output logic                      done_valid,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic [PAGES_W-1:0]        done_pages,
  output logic                      done_err
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [PAGES_W-1:0] PAGES_MAX = '1;
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]    ID_LAST   = ID_W'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARB        = 3'd1,
    S_PUSH       = 3'd2,
    S_WAIT_START = 3'd3,
    S_RUN        = 3'd4,
    S_DONE       = 3'd5,
    S_ERR        = 3'd6
  } state_e;

  state_e              state_q;
  logic [ID_W-1:0]     rr_q;
  logic [ID_W-1:0]     id_q;
  logic [PAGES_W-1:0]  pages_q;
  logic [PAGES_W-1:0]  pcnt_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                pp_prev_q;
  logic                push_q;
  logic                busy_q;
  logic                done_valid_q;
  logic                done_err_q;
  logic [ID_W-1:0]     done_id_q;
  logic [PAGES_W-1:0]  done_pages_q;

  logic                grant_found;
  logic [ID_W-1:0]     grant_id;
  logic [PAGES_W-1:0]  grant_pages;
  logic [PAGES_W-1:0]  pcnt_d;
  logic [TMO_W-1:0]    tmo_d;
  logic [ID_W-1:0]     rr_d;
  logic                rr_upd_en;
  logic                pp_rise;
  logic                prn_active;

  always_comb begin : grant_search
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
`ifdef PRN_SCHED_PRIO_EN
    // Requester 0 wins outright; the pointer rotates over 1..NREQ-1 only.
    if (req_valid[0]) begin
      grant_found = 1'b1;
    end else begin
      for (int k = 0; k < NREQ - 1; k++) begin
        idx = ((rr_q == '0) ? 0 : int'(rr_q) - 1) + k;
        if (idx >= NREQ - 1) idx = idx - (NREQ - 1);
        idx = idx + 1;
        if (!grant_found && req_valid[idx[ID_W-1:0]]) begin
          grant_found = 1'b1;
          grant_id    = idx[ID_W-1:0];
        end
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_found && req_valid[idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx[ID_W-1:0];
      end
    end
`endif
  end

  always_comb begin
    grant_pages = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == ID_W'(i)) grant_pages = req_pages[i*PAGES_W +: PAGES_W];
    end
  end

  always_comb begin
    pp_rise    = prn_printpage & ~pp_prev_q;
    prn_active = prn_warm | prn_loadpage | prn_printpage;
    pcnt_d     = (pcnt_q == PAGES_MAX) ? pcnt_q : pcnt_q + PAGES_W'(1);
    tmo_d      = tmo_q + TMO_W'(1);
    rr_d       = (id_q == ID_LAST) ? '0 : id_q + ID_W'(1);
`ifdef PRN_SCHED_PRIO_EN
    rr_upd_en  = (id_q != '0);
`else
    rr_upd_en  = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      id_q         <= '0;
      pages_q      <= '0;
      pcnt_q       <= '0;
      tmo_q        <= '0;
      pp_prev_q    <= 1'b0;
      push_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      done_id_q    <= '0;
      done_pages_q <= '0;
    end else begin
      pp_prev_q    <= prn_printpage;
      push_q       <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      done_id_q    <= '0;
      done_pages_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            state_q <= S_ARB;
            busy_q  <= 1'b1;
          end
        end
        S_ARB: begin
          // All requesters may have withdrawn since IDLE; fall back quietly.
          if (grant_found) begin
            id_q    <= grant_id;
            pages_q <= grant_pages;
            pcnt_q  <= '0;
            tmo_q   <= '0;
            if (grant_pages == '0) begin
              state_q      <= S_DONE;
              done_valid_q <= 1'b1;
              done_id_q    <= grant_id;
            end else begin
              state_q <= S_PUSH;
              push_q  <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_PUSH: begin
          state_q <= S_WAIT_START;
          tmo_q   <= '0;
        end
        S_WAIT_START: begin
          if (prn_warm | prn_loadpage) begin
            state_q <= S_RUN;
            tmo_q   <= '0;
          end else if (tmo_q == TMO_LAST) begin
            state_q      <= S_ERR;
            done_valid_q <= 1'b1;
            done_err_q   <= 1'b1;
            done_id_q    <= id_q;
            done_pages_q <= pcnt_q;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        S_RUN: begin
          if (pp_rise) pcnt_q <= pcnt_d;
          if (prn_active) begin
            tmo_q <= '0;
          end else if (pcnt_q >= pages_q) begin
            state_q      <= S_DONE;
            done_valid_q <= 1'b1;
            done_id_q    <= id_q;
            done_pages_q <= pcnt_q;
          end else if (tmo_q == TMO_LAST) begin
            state_q      <= S_ERR;
            done_valid_q <= 1'b1;
            done_err_q   <= 1'b1;
            done_id_q    <= id_q;
            done_pages_q <= pcnt_q;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        S_DONE, S_ERR: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (rr_upd_en) rr_q <= rr_d;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == S_ARB && grant_found) ? (NREQ'(1) << grant_id) : '0;
  assign prn_push   = push_q;
  assign prn_pages  = pages_q;
  assign busy       = busy_q;
  assign done_valid = done_valid_q;
  assign done_id    = done_id_q;
  assign done_pages = done_pages_q;
  assign done_err   = done_err_q;

endmodule
`default_nettype wire

// File: tb/tb_print_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_print_job_sched
// Brief    : Directed scoreboard bench for print_job_sched with a printer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_print_job_sched;

  localparam int NREQ    = 4;
  localparam int PAGES_W = 8;
  localparam int TIMEOUT = 255;
  localparam int ID_W    = 2;
  localparam int WARM    = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ*PAGES_W-1:0]  req_pages;
  logic [NREQ-1:0]          req_ready;
  logic                     prn_push;
  logic [PAGES_W-1:0]       prn_pages;
  logic                     prn_warm, prn_loadpage, prn_printpage;
  logic                     busy, done_valid, done_err;
  logic [ID_W-1:0]          done_id;
  logic [PAGES_W-1:0]       done_pages;

  always #5 clk = ~clk;

  print_job_sched #(.NREQ(NREQ), .PAGES_W(PAGES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_pages(req_pages), .req_ready(req_ready),
    .prn_push(prn_push), .prn_pages(prn_pages),
    .prn_warm(prn_warm), .prn_loadpage(prn_loadpage), .prn_printpage(prn_printpage),
    .busy(busy), .done_valid(done_valid), .done_id(done_id),
    .done_pages(done_pages), .done_err(done_err)
  );

  typedef struct { int id; int pages; int err; } done_t;

  int    total = 0;
  int    bad   = 0;
  int    exp_grant_q[$];
  done_t exp_done_q[$];
  logic [2:0] st_q[$];
  bit    prn_auto = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Printer: on each push, warm for WARM cycles then one load/print pair per page.
  initial begin : printer_model
    {prn_warm, prn_loadpage, prn_printpage} = 3'b000;
    forever begin
      @(posedge clk);
      #2;
      if (st_q.size() > 0) {prn_warm, prn_loadpage, prn_printpage} = st_q.pop_front();
      else                 {prn_warm, prn_loadpage, prn_printpage} = 3'b000;
      if (prn_push === 1'b1 && prn_auto) begin
        for (int i = 0; i < WARM; i++) st_q.push_back(3'b100);
        for (int p = 0; p < int'(prn_pages); p++) begin
          st_q.push_back(3'b010);
          st_q.push_back(3'b001);
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    done_t d;
    if (rst_n === 1'b1 && req_ready !== '0) begin
      if (exp_grant_q.size() == 0) chk("unexpected_grant", 32'(req_ready), 32'd0);
      else chk("grant", 32'(req_ready), 32'd1 << exp_grant_q.pop_front());
    end
    if (done_valid !== 1'b0) begin
      if (exp_done_q.size() == 0) begin
        chk("unexpected_done", 32'(done_valid), 32'd0);
      end else begin
        d = exp_done_q.pop_front();
        chk("done_id", 32'(done_id), d.id);
        chk("done_pages", 32'(done_pages), d.pages);
        chk("done_err", 32'(done_err), d.err);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pages(input int idx, input int p);
    req_pages[idx*PAGES_W +: PAGES_W] = PAGES_W'(p);
  endtask

  task automatic push_job(input int id, input int pages, input int err);
    exp_grant_q.push_back(id);
    exp_done_q.push_back('{id, pages, err});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_done_q.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_prn_push"}, 32'(prn_push), 32'd0);
    chk({tag, "_prn_pages"}, 32'(prn_pages), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_valid"}, 32'(done_valid), 32'd0);
    chk({tag, "_done_id"}, 32'(done_id), 32'd0);
    chk({tag, "_done_pages"}, 32'(done_pages), 32'd0);
    chk({tag, "_done_err"}, 32'(done_err), 32'd0);
  endtask

  // Hold req_valid until njobs grants are seen; busy must stay high inside each job.
  task automatic run_held(input logic [NREQ-1:0] v, input int njobs, input int budget);
    int seen;
    bit injob;
    seen  = 0;
    injob = 1'b0;
    req_valid = v;
    for (int i = 0; i < budget && seen < njobs; i++) begin
      @(negedge clk);
      if (injob) chk("busy_mid_job", 32'(busy), 32'd1);
      if (req_ready !== '0) begin
        seen++;
        injob = 1'b1;
      end
      if (done_valid === 1'b1) injob = 1'b0;
    end
    chk("held_grant_count", seen, njobs);
    @(negedge clk);
    req_valid = '0;
    wait_idle("held_idle", 2000);
  endtask

  initial begin : main
    int cnt;
    rst_n     = 1'b0;
    req_valid = '0;
    req_pages = '0;
    cyc(3);
    check_zero("reset");
    rst_n = 1'b1;
    cyc(2);

    // Contention: all four held, one page each.
    for (int j = 0; j < NREQ; j++) set_pages(j, 1);
    for (int j = 0; j < 5; j++) begin
`ifdef PRN_SCHED_PRIO_EN
      push_job(0, 1, 0);
`else
      push_job(j % NREQ, 1, 0);
`endif
    end
    run_held(4'b1111, 5, 2000);

    // Single job on requester 2, three pages.
    set_pages(2, 3);
    push_job(2, 3, 0);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h4);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_push_early", 32'(prn_push), 32'd0);
    @(negedge clk);
    chk("single_push", 32'(prn_push), 32'd1);
    chk("single_prn_pages", 32'(prn_pages), 32'd3);
    req_valid = '0;
    @(negedge clk);
    chk("single_push_pulse", 32'(prn_push), 32'd0);
    chk("single_pages_held", 32'(prn_pages), 32'd3);
    wait_idle("single_idle", 500);

    // Zero pages: DONE straight after ARB, no push.
    set_pages(1, 0);
    push_job(1, 0, 0);
    req_valid = 4'b0010;
    cyc(2);
    chk("zero_done_valid", 32'(done_valid), 32'd1);
    chk("zero_no_push", 32'(prn_push), 32'd0);
    req_valid = '0;
    @(negedge clk);
    chk("zero_busy_low", 32'(busy), 32'd0);
    chk("zero_done_pulse", 32'(done_valid), 32'd0);

    // Timeout: printer stays silent after the push.
    prn_auto = 1'b0;
    set_pages(2, 4);
    push_job(2, 0, 1);
    req_valid = 4'b0100;
    cyc(2);
    chk("tmo_push", 32'(prn_push), 32'd1);
    req_valid = '0;
    @(negedge clk);
    cyc(TIMEOUT - 1);
    chk("tmo_not_yet", 32'(done_valid), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("tmo_done_valid", 32'(done_valid), 32'd1);
    chk("tmo_done_err", 32'(done_err), 32'd1);
    prn_auto = 1'b1;
    wait_idle("tmo_idle", 20);

    // Normal service after a timeout; leaves the pointer at 2.
    set_pages(1, 2);
    push_job(1, 2, 0);
    req_valid = 4'b0010;
    cyc(2);
    req_valid = '0;
    wait_idle("after_tmo_idle", 500);

    // Reset during RUN once two of five pages have printed.
    set_pages(1, 5);
    exp_grant_q.push_back(1);
    req_valid = 4'b0010;
    cyc(2);
    req_valid = '0;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 2; i++) begin
      @(negedge clk);
      if (prn_printpage === 1'b1) cnt++;
    end
    chk("rst_pages_seen", cnt, 2);
    @(negedge clk);
    chk("rst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    st_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check_zero("midjob_reset");

    // Pointer must be back at 0: requesters 0 and 3 held.
    set_pages(0, 1);
    set_pages(3, 1);
    for (int j = 0; j < 4; j++) begin
`ifdef PRN_SCHED_PRIO_EN
      push_job(0, 1, 0);
`else
      push_job((j % 2 == 0) ? 0 : 3, 1, 0);
`endif
    end
    run_held(4'b1001, 4, 2000);

    cyc(5);
    chk("scoreboard_empty", exp_done_q.size() + exp_grant_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/print_job_sched.md
Name: print_job_sched

Overview:
- Shares one page-printer engine between NREQ requesters.
- Arbitrates job requests round-robin and drives the printer's push/pages inputs.
- Tracks progress by watching the printer's warm/loadpage/printpage status outputs, and reports completion or timeout per job.
- Sits between the host-side job sources and the printer core.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PAGES_W, 8, page-count width; matches the printer pages input.
- TIMEOUT, 255, max cycles with no printer activity before a job is aborted.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid  in  NREQ  per-requester job request, held until accepted
- req_pages  in  NREQ*PAGES_W  page count for each requester; slice i = bits [i*PAGES_W +: PAGES_W]
- req_ready  out  NREQ  one-hot, 1-cycle accept pulse
- prn_push  out  1  1-cycle start pulse to printer
- prn_pages  out  PAGES_W  page count to printer, held stable for the whole job
- prn_warm  in  1  printer status
- prn_loadpage  in  1  printer status
- prn_printpage  in  1  printer status
- busy  out  1  high from accept until DONE/ERR exit
- done_valid  out  1  1-cycle job-finished pulse
- done_id  out  $clog2(NREQ)  requester of finished job
- done_pages  out  PAGES_W  pages actually printed
- done_err  out  1  qualifies done_valid; 1 = timeout abort

Behaviour:
- Reset is synchronous: rst_n sampled low at a clk edge resets on that edge.
- Reset values: state=IDLE, rr pointer=0, all outputs 0, page counter=0, timeout counter=0.
- Reset mid-job aborts immediately; no done_valid is issued for the aborted job.
- Status sampling: printpage rising edge = cycle where prn_printpage=1 and its registered previous value=0.
- Printer idle = warm, loadpage and printpage all 0.

FSM states and transitions:
- IDLE: if any req_valid, go to ARB next cycle; else stay.
- ARB (1 cycle):
  - Grant the first valid requester searching from the rr pointer upward, with wrap.
  - Assert req_ready[grant]; latch id and pages.
  - pages==0 -> DONE (no push, done_pages=0, done_err=0). Else -> PUSH.
- PUSH (1 cycle): prn_push=1, timeout counter cleared -> WAIT_START.
- WAIT_START:
  - prn_warm or prn_loadpage seen -> RUN, timeout counter cleared.
  - Timeout counter reaches TIMEOUT -> ERR.
- RUN:
  - Each printpage rising edge increments the page counter (saturating at 2^PAGES_W-1) and clears the timeout counter.
  - Any nonzero status bit also clears the timeout counter.
  - Page counter == latched pages and printer idle -> DONE.
  - Timeout counter reaches TIMEOUT -> ERR.
- DONE (1 cycle):
  - done_valid=1, done_err=0, done_id, done_pages=page counter.
  - rr pointer = id+1 mod NREQ -> IDLE.
- ERR (1 cycle):
  - done_valid=1, done_err=1, done_pages=pages printed so far.
  - rr pointer = id+1 mod NREQ -> IDLE.

Rules and boundary conditions:
- A requester dropping req_valid before acceptance is legal; it is simply not granted.
- req_valid is ignored outside IDLE/ARB; at most one job in flight.
- req_ready is never asserted outside ARB.
- Simultaneous requests: exactly one grant per ARB; the others wait, and fairness comes from the rr pointer.
- Same requester re-requesting immediately after DONE is granted only if no other requester is valid.
- Printer printing more pages than requested: counter keeps counting (saturating); DONE fires once the printer is idle with counter >= pages.
- busy = (state != IDLE).
- Minimum latency, req_valid to prn_push: 2 cycles (IDLE, ARB, PUSH).

Optional Feature:
- PRN_SCHED_PRIO_EN defined: requester 0 has strict priority; whenever req_valid[0]=1 in ARB it wins regardless of the rr pointer. The rr pointer governs requesters 1..NREQ-1 only and is not updated by requester-0 grants.
- Not defined: pure round-robin over all requesters as above.

Test Plan:
- Single job: req_valid[2]=1, pages=3; printer model gives warm 5 cycles, then 3 load/print pairs, then idle. Expect req_ready[2] pulse, prn_push 2 cycles after req_valid, done_valid with id=2, pages=3, err=0.
- Contention: req_valid=4'b1111 held, each job pages=1. Expect grants in order 0,1,2,3,0; one done_valid per job; busy never drops mid-job.
- Zero pages: req_valid[1]=1, pages=0. Expect no prn_push; done_valid 1 cycle after ARB with pages=0, err=0.
- Timeout: printer model never raises status after push, TIMEOUT=255. Expect done_err=1, done_pages=0 exactly 255 cycles after WAIT_START entry; next request is served normally.
- Reset mid-job: drop rst_n for 1 cycle during RUN with 2 of 5 pages printed. Expect all outputs 0 next cycle, no done_valid, rr pointer=0.
- With PRN_SCHED_PRIO_EN: req_valid[0] and req_valid[3] continuously asserted. Expect requester 0 granted every ARB; without the macro, grants alternate 0,3,0,3.
